// File: rtl/alarm_clock_input_ctrl.sv
// Button front end for the 12-hour alarm clock: edits time or alarm fields and issues a one-cycle load strobe.
// Optional edit timeout with shadow restore is built when ALARM_CTRL_TIMEOUT_EN is defined.
module alarm_clock_input_ctrl (
    input  logic       Clock_1sec,
    input  logic       reset,
    input  logic       btn_set,
    input  logic       btn_inc,
    input  logic       btn_mode,
    input  logic       btn_view_alarm,
    output logic [3:0] set_hours,
    output logic [5:0] set_mins,
    output logic [5:0] set_secs,
    output logic       set_am_pm,
    output logic       load_time,
    output logic       load_alarm,
    output logic [1:0] display_state,
    output logic [1:0] edit_field,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        ED_HOURS,
        ED_MINS,
        ED_SECS,
        ED_AMPM,
        COMMIT
    } state_t;

    localparam logic [1:0] DISP_INPUT = 2'b10;

    state_t state;
    logic   set_q;
    logic   inc_q;
    logic   target_alarm;
    logic   set_press;
    logic   inc_press;
    logic   editing;
    logic   timeout;

    // Edge detect against the previous sample so the press is acted on at the same edge it is seen.
    assign set_press = btn_set & ~set_q;
    assign inc_press = btn_inc & ~inc_q;
    assign editing   = (state == ED_HOURS) || (state == ED_MINS) ||
                       (state == ED_SECS)  || (state == ED_AMPM);

    function automatic logic [3:0] hours_inc(input logic [3:0] h);
        return (h >= 4'd12 || h == 4'd0) ? 4'd1 : h + 4'd1;
    endfunction

    function automatic logic [5:0] sixty_inc(input logic [5:0] v);
        return (v >= 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

`ifdef ALARM_CTRL_TIMEOUT_EN
    logic [4:0] idle_cnt;
    logic [3:0] sh_hours;
    logic [5:0] sh_mins;
    logic [5:0] sh_secs;
    logic       sh_am_pm;

    // Thirtieth consecutive edit cycle without a press abandons the edit.
    assign timeout = editing && (idle_cnt == 5'd29) && !set_press && !inc_press;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge Clock_1sec or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            set_q         <= 1'b0;
            inc_q         <= 1'b0;
            target_alarm  <= 1'b0;
            set_hours     <= 4'd12;
            set_mins      <= 6'd0;
            set_secs      <= 6'd0;
            set_am_pm     <= 1'b0;
            load_time     <= 1'b0;
            load_alarm    <= 1'b0;
            display_state <= 2'b00;
            edit_field    <= 2'd0;
            busy          <= 1'b0;
`ifdef ALARM_CTRL_TIMEOUT_EN
            idle_cnt      <= 5'd0;
            sh_hours      <= 4'd12;
            sh_mins       <= 6'd0;
            sh_secs       <= 6'd0;
            sh_am_pm      <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking throughout so every decision below uses pre-edge register values.
            set_q      <= btn_set;
            inc_q      <= btn_inc;
            load_time  <= 1'b0;
            load_alarm <= 1'b0;
`ifdef ALARM_CTRL_TIMEOUT_EN
            idle_cnt   <= (editing && !set_press && !inc_press) ? idle_cnt + 5'd1 : 5'd0;
`endif
            if (timeout) begin
                state         <= IDLE;
                busy          <= 1'b0;
                edit_field    <= 2'd0;
                display_state <= {1'b0, btn_view_alarm};
`ifdef ALARM_CTRL_TIMEOUT_EN
                set_hours     <= sh_hours;
                set_mins      <= sh_mins;
                set_secs      <= sh_secs;
                set_am_pm     <= sh_am_pm;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        display_state <= {1'b0, btn_view_alarm};
                        if (set_press) begin
                            state         <= ED_HOURS;
                            target_alarm  <= btn_mode;
                            busy          <= 1'b1;
                            edit_field    <= 2'd0;
                            display_state <= DISP_INPUT;
`ifdef ALARM_CTRL_TIMEOUT_EN
                            sh_hours      <= set_hours;
                            sh_mins       <= set_mins;
                            sh_secs       <= set_secs;
                            sh_am_pm      <= set_am_pm;
`endif
                        end
                    end
                    ED_HOURS: begin
                        if (set_press) begin
                            state      <= ED_MINS;
                            edit_field <= 2'd1;
                        end else if (inc_press) begin
                            set_hours <= hours_inc(set_hours);
                        end
                    end
                    ED_MINS: begin
                        if (set_press) begin
                            // The alarm has no seconds field.
                            state      <= target_alarm ? ED_AMPM : ED_SECS;
                            edit_field <= target_alarm ? 2'd3 : 2'd2;
                        end else if (inc_press) begin
                            set_mins <= sixty_inc(set_mins);
                        end
                    end
                    ED_SECS: begin
                        if (set_press) begin
                            state      <= ED_AMPM;
                            edit_field <= 2'd3;
                        end else if (inc_press) begin
                            set_secs <= sixty_inc(set_secs);
                        end
                    end
                    ED_AMPM: begin
                        if (set_press) begin
                            state      <= COMMIT;
                            edit_field <= 2'd0;
                            load_time  <= ~target_alarm;
                            load_alarm <= target_alarm;
                        end else if (inc_press) begin
                            set_am_pm <= ~set_am_pm;
                        end
                    end
                    COMMIT: begin
                        state         <= IDLE;
                        busy          <= 1'b0;
                        edit_field    <= 2'd0;
                        display_state <= {1'b0, btn_view_alarm};
                    end
                    default: begin
                        state         <= IDLE;
                        busy          <= 1'b0;
                        edit_field    <= 2'd0;
                        display_state <= {1'b0, btn_view_alarm};
                    end
                endcase
            end
        end
    end

endmodule
